spart_rx: RTL
=============

// Module: spart_rx
// PURPOSE
//  Serial receiver half of the SPART. Recovers 8N1 frames from rxd: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1).
//  Oversamples on the shared baud-generator enable pulse (16 enables per bit) and samples each bit at its centre.
//  Holds the received byte for the bus interface and flags it with rda until the CPU reads it.
//  Sits beside the SPART transmitter and shares its enable, ioaddr and iorw inputs.
// PARAMETERS
//  OVERSAMPLE   16  enable pulses per bit period; must be even, >= 4
//  DATA_BITS    8   data bits per frame
//  SYNC_STAGES  2   flops in the rxd metastability synchronizer, >= 2
// PORTS
//  clk        in   1          system clock; all flops rise on posedge clk
//  rst        in   1          asynchronous, active-high reset
//  enable     in   1          baud tick from baud generator, 1 clk wide, OVERSAMPLE per bit
//  rxd        in   1          serial line, asynchronous to clk, idles high
//  ioaddr     in   2          bus register address; 2'b00 = data register
//  iorw       in   1          1 = read, 0 = write
//  rx_data    out  DATA_BITS  last good received byte
//  rda        out  1          receive data available
//  ferr       out  1          framing error: stop bit sampled 0
//  ovr        out  1          overrun: new byte completed while rda=1
// BEHAVIOUR
//  Reset: rx_data=8'h00, rda=0, ferr=0, ovr=0, state=IDLE, synchronizer flops=1, counters=0.
//  rxd passes SYNC_STAGES flops -> rxs; all decisions use rxs only. Falling edge = rxs_d1==1 && rxs==0.
//  en_cnt counts enable pulses in a bit; bit_cnt counts data bits (0..DATA_BITS). Both advance only on enable.
//  FSM states:
//   IDLE:  en_cnt=0. On falling edge of rxs -> START.
//   START: on enable en_cnt++. When en_cnt reaches OVERSAMPLE/2 (8), sample rxs:
//          rxs=1 -> false start, go to IDLE, no flag changes; rxs=0 -> DATA, en_cnt=0, bit_cnt=0.
//   DATA:  on enable en_cnt++. When en_cnt reaches OVERSAMPLE (16), sample rxs into shift reg
//          ({rxs, sr[7:1]}, LSB first), en_cnt=0, bit_cnt++. After DATA_BITS samples -> STOP.
//   STOP:  when en_cnt reaches OVERSAMPLE, sample rxs, go to IDLE.
//          rxs=1: rx_data<=sr, rda<=1, ferr<=0, ovr<=rda (old value). rxs=0: ferr<=1, rx_data and rda unchanged.
//  Each sample point is centre of bit; stop sample at 9.5 bit-times after start edge (at 16x).
//  Latency: rda/rx_data update on the clk edge after the cycle in which the stop sample's enable is high.
//  Read strobe rd = (ioaddr==2'b00 && iorw==1). rd clears rda and ovr next edge; rx_data unaffected.
//  Simultaneous rd and frame completion in the same cycle: set wins (rda=1, rx_data new, ovr=0 since byte was read).
//  enable low: every counter and the FSM hold; rxs may still be sampled for edge only in IDLE.
//  After a framing error, line held low does not retrigger: IDLE needs a fresh 1->0 edge (break stays ignored).
//  Reset mid-frame: everything returns to reset values immediately; partial byte discarded.
//  ferr is sticky until the next good frame or reset; reads do not clear it.
// STRUCTURE
//  spart_pkg: state encodings (IDLE/START/DATA/STOP), IOADDR_DATA=2'b00, default OVERSAMPLE and DATA_BITS.
//  Sub-module spart_rx_sync: SYNC_STAGES-deep synchronizer, reset-to-1, output rxs plus registered rxs_d1.
//  FSM, counters, shift register and flag flops stay in spart_rx.
// TESTING
//  1. Send 8'hA5 at 16 enables/bit, no read -> rx_data=8'hA5, rda=1, ferr=0, ovr=0 one clk after stop sample.
//  2. Then rd pulse (ioaddr=00, iorw=1) -> rda=0 next clk, rx_data still 8'hA5; read with ioaddr=01 -> no change.
//  3. Low glitch on rxd for 5 enables then high -> FSM back to IDLE at 8th enable, rda/ferr unchanged.
//  4. Send 8'h3C with stop bit 0 -> ferr=1, rda=0, rx_data keeps prior value; next good 8'h81 -> ferr=0, rda=1.
//  5. Send 8'h11 then 8'h22 without reading -> rx_data=8'h22, ovr=1; rd coinciding with 3rd frame end -> rda=1, ovr=0.
//  6. Assert rst at bit 4 of 8'hFF -> all outputs reset at once; following frame 8'h5A received correctly.

Source files
------------

// File: rtl/spart_rx_pkg.sv
// Shared types and constants for the SPART receiver: FSM encoding, bus
// register address and default frame geometry.
package spart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [1:0]  IOADDR_DATA      = 2'b00;
    localparam int unsigned DEF_OVERSAMPLE   = 16;
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned DEF_SYNC_STAGES  = 2;

    // A CPU read of the data register.
    function automatic logic is_data_read(input logic [1:0] ioaddr, input logic iorw);
        return (ioaddr == IOADDR_DATA) && iorw;
    endfunction

endpackage

// File: rtl/spart_rx_if.sv
// Bus-side view of the SPART receiver: address/direction from the CPU and
// the received byte with its status flags back.
interface spart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [1:0]           ioaddr;
    logic                 iorw;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 ferr;
    logic                 ovr;

    modport master (
        output ioaddr, iorw,
        input  rx_data, rda, ferr, ovr
    );

    modport slave (
        input  ioaddr, iorw,
        output rx_data, rda, ferr, ovr
    );
endinterface

// File: rtl/spart_rx_sync.sv
// Metastability synchronizer for the asynchronous rxd line, idling high,
// plus a one-cycle delayed copy used for edge detection.
module spart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxs,
    output logic rxs_d1
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            rxs_d1 <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
            rxs_d1 <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: recovers 8N1 frames from rxd using the shared oversampling
// baud enable, and presents the byte with rda/ferr/ovr to the bus.
module spart_rx
    import spart_rx_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rxd,
    spart_rx_if.slave  bus
);

    localparam int unsigned EN_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [EN_W-1:0]  EN_HALF  = EN_W'(OVERSAMPLE / 2 - 1);
    localparam logic [EN_W-1:0]  EN_LAST  = EN_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_e            state;
    logic [EN_W-1:0]      en_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] sr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rda;
    logic                 ferr;
    logic                 ovr;

    logic rxs;
    logic rxs_d1;
    logic fall_c;
    logic rd_c;
    logic stop_good_c;

    spart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .rxs    (rxs),
        .rxs_d1 (rxs_d1)
    );

    assign fall_c      = rxs_d1 & ~rxs;
    assign rd_c        = is_data_read(bus.ioaddr, bus.iorw);
    // Stop bit sampled high on its final enable: a good frame completes this cycle.
    assign stop_good_c = (state == STOP) && enable && (en_cnt == EN_LAST) && rxs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            en_cnt  <= '0;
            bit_cnt <= '0;
            sr      <= '0;
            rx_data <= '0;
            rda     <= 1'b0;
            ferr    <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    en_cnt  <= '0;
                    bit_cnt <= '0;
                    if (fall_c) begin
                        state <= START;
                    end
                end
                // Half a bit in: confirm the start bit, else treat as a glitch.
                START: begin
                    if (enable) begin
                        if (en_cnt == EN_HALF) begin
                            en_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= rxs ? IDLE : DATA;
                        end else begin
                            en_cnt <= en_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (enable) begin
                        if (en_cnt == EN_LAST) begin
                            en_cnt  <= '0;
                            sr      <= {rxs, sr[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end
                        end else begin
                            en_cnt <= en_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (enable) begin
                        if (en_cnt == EN_LAST) begin
                            en_cnt <= '0;
                            state  <= IDLE;
                            if (rxs) begin
                                rx_data <= sr;
                                ferr    <= 1'b0;
                            end else begin
                                ferr    <= 1'b1;
                            end
                        end else begin
                            en_cnt <= en_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion outranks a read; a same-cycle read means the old byte was consumed.
            if (stop_good_c) begin
                rda <= 1'b1;
                ovr <= rda & ~rd_c;
            end else if (rd_c) begin
                rda <= 1'b0;
                ovr <= 1'b0;
            end
        end
    end

    assign bus.rx_data = rx_data;
    assign bus.rda     = rda;
    assign bus.ferr    = ferr;
    assign bus.ovr     = ovr;

endmodule
